// File: rtl/bram_delay_line_if.sv
// ==== bram_delay_line_if : configuration and sample stream bundle for bram_delay_line ====
// ==== rev 1.0 ====
`default_nettype none

interface bram_delay_line_if #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 512,
  parameter int CHANNELS = 1
);
  localparam int DW = WIDTH * CHANNELS;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          cfg_load;
  logic [CW-1:0] cfg_delay;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          primed;

  modport master (
    output cfg_load, cfg_delay, in_valid, in_data,
    input  out_valid, out_data, primed
  );

  modport slave (
    input  cfg_load, cfg_delay, in_valid, in_data,
    output out_valid, out_data, primed
  );
endinterface

`default_nettype wire

// File: rtl/bram_delay_line.sv
// ==== bram_delay_line : programmable multi-lane delay line on one circular block RAM ====
// ==== rev 1.0 ====
`default_nettype none

module bram_delay_line #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 512,
  parameter int CHANNELS = 1
) (
  input wire                clk,
  input wire                rst_n,
  bram_delay_line_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = WIDTH * CHANNELS;
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  typedef enum logic [0:0] {
    FILLING = 1'b0,
    PRIMED  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] wptr_q;
  logic [CW-1:0] fill_q;
  logic [CW-1:0] fill_inc;
  logic [CW-1:0] delay_q;
  logic [CW-1:0] delay_clamped;
  logic          push;
  logic          emit;
  logic [AW-1:0] raddr;
  logic          out_valid_q;
  logic          data_seen_q;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_data;

  // cfg_load takes priority: a coincident sample is dropped entirely
  assign push     = bus.in_valid & ~bus.cfg_load;
  assign emit     = push & (fill_q >= delay_q);
  assign fill_inc = (fill_q == DEPTH_CW) ? fill_q : fill_q + CW'(1);
  // DEPTH is a power of two, so the low bits give the modulo for free
  assign raddr    = wptr_q - delay_q[AW-1:0];

  always_comb begin
    delay_clamped = bus.cfg_delay;
    if (bus.cfg_delay == '0) begin
      delay_clamped = CW'(1);
    end else if (bus.cfg_delay > DEPTH_CW) begin
      delay_clamped = DEPTH_CW;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILLING: if (push && (fill_inc >= delay_q)) state_d = PRIMED;
      PRIMED:  state_d = PRIMED;
      default: state_d = FILLING;
    endcase
    if (bus.cfg_load) begin
      state_d = FILLING;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILLING;
      wptr_q      <= '0;
      fill_q      <= '0;
      delay_q     <= DEPTH_CW;
      out_valid_q <= 1'b0;
      data_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= emit;
      if (emit) begin
        data_seen_q <= 1'b1;
      end
      if (bus.cfg_load) begin
        delay_q <= delay_clamped;
        fill_q  <= '0;
      end else if (bus.in_valid) begin
        wptr_q <= wptr_q + AW'(1);
        fill_q <= fill_inc;
      end
    end
  end

  // Plain RAM process, no reset: both accesses are non-blocking, so a read
  // of the address being written returns the old entry (read-first).
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= bus.in_data;
    end
    if (emit) begin
      rd_data <= mem[raddr];
    end
  end

  // The RAM output register cannot take an async reset, so out_data is
  // gated to zero until the first beat after reset.
  assign bus.out_data  = data_seen_q ? rd_data : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.primed    = (state_q == PRIMED);

endmodule

`default_nettype wire

// File: tb/tb_bram_delay_line.sv
// ==== tb_bram_delay_line : directed scoreboard bench for bram_delay_line ====
// ==== rev 1.0 ====
`default_nettype none

module tb_bram_delay_line;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 8;
  localparam int CHANNELS = 2;
  localparam int DW       = WIDTH * CHANNELS;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  bram_delay_line_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) bus ();

  bram_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: any valid beat, or any cycle where a beat is due, is compared
  always @(negedge clk) begin
    bit            exp_v;
    logic [DW-1:0] exp_d;
    exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
    exp_d = exp_v ? sb[0].data : '0;
    if (exp_v || (bus.out_valid === 1'b1)) begin
      checks++;
      if ((bus.out_valid !== exp_v) || (exp_v && (bus.out_data !== exp_d))) begin
        errors++;
        $display("FAIL out_beat cyc=%0d: got valid=%b data=%h, want valid=%b data=%h",
                 cyc, bus.out_valid, bus.out_data, exp_v, exp_d);
      end
      if (exp_v) void'(sb.pop_front());
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input bit ev, input logic [DW-1:0] ed);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (ev) sb.push_back(exp_t'{cyc: cyc, data: ed});
  endtask

  task automatic cfg(input logic [CW-1:0] d, input bit with_valid, input logic [DW-1:0] vd);
    bus.cfg_load  = 1'b1;
    bus.cfg_delay = d;
    bus.in_valid  = with_valid;
    bus.in_data   = vd;
    @(posedge clk);
    #1;
    bus.cfg_load  = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int gaps[8];
    gaps = '{0, 1, 2, 3, 0, 2, 1, 3};
    bus.cfg_load  = 1'b0;
    bus.cfg_delay = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data",  32'(bus.out_data),  32'd0);
    check("reset_primed",    32'(bus.primed),    32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // Default delay = DEPTH: read-first at the write address on every wrap
    for (int i = 1; i <= 20; i++) begin
      push(DW'(i), i >= 9, DW'(i - 8));
      if (i == 7) check("primed_before_depth", 32'(bus.primed), 32'd0);
      if (i == 8) check("primed_at_depth",     32'(bus.primed), 32'd1);
    end

    // Delay 4, back-to-back
    cfg(CW'(4), 1'b0, '0);
    check("primed_after_cfg", 32'(bus.primed), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      push(DW'(100 + i), i >= 5, DW'(100 + i - 4));
      if (i == 3) check("primed_d4_push3", 32'(bus.primed), 32'd0);
      if (i == 4) check("primed_d4_push4", 32'(bus.primed), 32'd1);
    end
    idle(2);
    check("out_data_hold", 32'(bus.out_data), 32'd106);

    // Delay 3 with idle gaps between pushes
    cfg(CW'(3), 1'b0, '0);
    for (int i = 1; i <= 8; i++) begin
      if (gaps[i-1] > 0) idle(gaps[i-1]);
      push(DW'(i), i >= 4, DW'(i - 3));
    end

    // Clamp 0 -> 1
    cfg(CW'(0), 1'b0, '0);
    push(DW'(7), 1'b0, '0);
    push(DW'(9), 1'b1, DW'(7));

    // Clamp DEPTH+5 -> DEPTH
    cfg(CW'(DEPTH + 5), 1'b0, '0);
    for (int i = 1; i <= 9; i++) begin
      push(DW'(200 + i), i == 9, DW'(201));
      if (i == 8) check("primed_clamped_depth", 32'(bus.primed), 32'd1);
    end

    // Mid-stream reconfigure together with a sample that must be dropped
    cfg(CW'(5), 1'b0, '0);
    for (int i = 1; i <= 6; i++) push(DW'(300 + i), i == 6, DW'(301));
    check("primed_d5", 32'(bus.primed), 32'd1);
    cfg(CW'(2), 1'b1, DW'(16'hDEAD));
    check("primed_fall_on_cfg", 32'(bus.primed), 32'd0);
    push(DW'(16'h0A0A), 1'b0, '0);
    push(DW'(16'h0B0B), 1'b0, '0);
    push(DW'(16'h0C0C), 1'b1, DW'(16'h0A0A));
    push(DW'(16'h0D0D), 1'b1, DW'(16'h0B0B));
    @(negedge clk);
    #2;
    check("valid_before_reset", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_out_data",  32'(bus.out_data),  32'd0);
    check("async_rst_primed",    32'(bus.primed),    32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    // After reset the delay is DEPTH again
    for (int i = 1; i <= 9; i++) push(DW'(400 + i), i == 9, DW'(401));

    // Two lanes, delay 2: lane order must be preserved
    cfg(CW'(2), 1'b0, '0);
    push(DW'(16'hA101), 1'b0, '0);
    push(DW'(16'hB202), 1'b0, '0);
    push(DW'(16'hC303), 1'b1, DW'(16'hA101));
    push(DW'(16'hD404), 1'b1, DW'(16'hB202));
    idle(3);

    check("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
